vga_keyboard_pic: RTL and testbench

VGA_KEYBOARD_PIC -- requirements
Module: vga_keyboard_pic

---
 rtl/vga_pic_pkg.sv | 55 +++++
 rtl/vga_glyph_rom.sv | 38 +++
 rtl/vga_keyboard_pic.sv | 153 +++++++++++++++
 tb/tb_vga_keyboard_pic.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_pic_pkg.sv
// Shared colours, song codes and pipeline types for the keyboard/banner pixel generator.
package vga_pic_pkg;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] GRAY   = 12'h888;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] CYAN   = 12'h0FF;
    localparam logic [11:0] KEY_ON = GRAY;

    localparam int unsigned GLYPH_W = 32;
    localparam int unsigned GLYPH_H = 32;

    typedef enum logic [1:0] {
        SongNone = 2'd0,
        Song1    = 2'd1,
        Song2    = 2'd2,
        Song3    = 2'd3
    } song_e;

    localparam logic [2:0] SONG1_CHARS   = 3'd3;
    localparam logic [2:0] DEFAULT_CHARS = 3'd4;

    // Stage-1 result: solid colour, or glyph lookup with colour as background.
    typedef struct packed {
        logic        glyph;
        logic [4:0]  bit_idx;
        logic [11:0] colour;
    } pix_stage_t;

    function automatic song_e decode_song(input logic [3:0] n);
        case (n)
            4'd1:    return Song1;
            4'd2:    return Song2;
            4'd3:    return Song3;
            default: return SongNone;
        endcase
    endfunction

    function automatic logic [2:0] song_chars(input song_e s);
        return (s == Song1) ? SONG1_CHARS : DEFAULT_CHARS;
    endfunction

    function automatic logic [11:0] song_bg(input song_e s);
        case (s)
            Song1:   return CYAN;
            Song2:   return GREEN;
            Song3:   return BLUE;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/vga_glyph_rom.sv
// Banner glyph ROM: {sel, char, row} -> 32-pixel row, registered read. Bit 0 is the leftmost pixel.
module vga_glyph_rom
    import vga_pic_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [8:0]         addr_i,
    output logic [GLYPH_W-1:0] row_o
);

    logic [GLYPH_W-1:0] row_d, row_q;

    // Block pattern per banner/char; two blank rows top and bottom, char 3 of song 1 unused.
    function automatic logic [31:0] glyph_row(input logic [1:0] s, input logic [1:0] c,
                                              input logic [4:0] r);
        logic [31:0] base;
        base = {8{s, c}};
        if ((s == Song1 && c == 2'd3) || r < 5'd2 || r > 5'd29) begin
            return '0;
        end
        return r[2] ? (base ^ 32'hFFFF_0000) : (base ^ 32'h0000_FFFF);
    endfunction

    always_comb begin
        row_d = glyph_row(addr_i[8:7], addr_i[6:5], addr_i[4:0]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/vga_keyboard_pic.sv
// Piano-keyboard plus song-banner pixel generator; two-stage pipeline from (pix_x, pix_y) to pix_data.
module vga_keyboard_pic
    import vga_pic_pkg::*;
#(
    parameter int unsigned H_VALID      = 640,
    parameter int unsigned V_VALID      = 480,
    parameter int unsigned NUM_KEYS     = 7,
    parameter int unsigned KEY_W        = 40,
    parameter int unsigned BANNER_X0    = 448,
    parameter int unsigned BANNER_Y0    = 0,
    parameter int unsigned HOLD_FRAMES  = 8,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                vga_clk,
    input  logic                sys_rst_n,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic [NUM_KEYS-1:0] status,
    input  logic [3:0]          num,
    output logic [11:0]         pix_data
);

    localparam logic [10:0] KEYS_END = 11'(NUM_KEYS * KEY_W);
    localparam logic [10:0] BAN_X0   = 11'(BANNER_X0);
    localparam logic [10:0] BAN_Y0   = 11'(BANNER_Y0);
    localparam logic [10:0] BAN_Y1   = 11'(BANNER_Y0 + GLYPH_H);
    localparam logic [10:0] X_END    = 11'(H_VALID);
    localparam logic [10:0] Y_END    = 11'(V_VALID);
    localparam int unsigned HOLD_W   = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic                frame_start;
    logic [10:0]         px, py, ban_x1;
    logic [6:0]          rel_x;
    logic [4:0]          rel_y;
    logic [2:0]          chars;
    logic                in_box;
    logic [8:0]          rom_addr;
    logic [GLYPH_W-1:0]  rom_row;
    logic [NUM_KEYS-1:0] lit;

    song_e               sel_d, sel_q;
    logic [HOLD_W-1:0]   hold_d [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
    logic [BLINK_W-1:0]  blink_cnt_d, blink_cnt_q;
    logic                blink_phase_d, blink_phase_q;
    pix_stage_t          stage_d, stage_q;
    logic [11:0]         pix_data_d, pix_data_q;

    assign frame_start = (pix_x == 10'd0) && (pix_y == 10'd0);

    // Per-frame state: song latch, key hold timers and banner blink.
    always_comb begin
        sel_d         = frame_start ? decode_song(num) : sel_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            hold_d[k] = hold_q[k];
            lit[k]    = status[k] | (hold_q[k] != '0);
            if (status[k]) begin
                hold_d[k] = HOLD_W'(HOLD_FRAMES);
            end else if (frame_start && hold_q[k] != '0) begin
                hold_d[k] = hold_q[k] - HOLD_W'(1);
            end
        end
    end

    // Stage 1: region decode and glyph ROM address.
    always_comb begin
        px       = {1'b0, pix_x};
        py       = {1'b0, pix_y};
        chars    = song_chars(sel_q);
        ban_x1   = BAN_X0 + {3'b000, chars, 5'b00000};
        rel_x    = 7'(px - BAN_X0);
        rel_y    = 5'(py - BAN_Y0);
        in_box   = (px >= BAN_X0) && (px < ban_x1) && (py >= BAN_Y0) && (py < BAN_Y1);
        rom_addr = {sel_q, rel_x[6:5], rel_y};

        stage_d.glyph   = 1'b0;
        stage_d.bit_idx = rel_x[4:0];
        stage_d.colour  = BLACK;
        if (px >= X_END || py >= Y_END) begin
            stage_d.colour = BLACK;
        end else if (px < KEYS_END) begin
            stage_d.colour = WHITE;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (px >= 11'(k * KEY_W) && px < 11'((k + 1) * KEY_W)) begin
                    if (px == 11'(k * KEY_W + KEY_W - 1)) begin
                        stage_d.colour = BLACK;
                    end else if (lit[k]) begin
                        stage_d.colour = KEY_ON;
                    end
                end
            end
        end else if (px < BAN_X0) begin
            stage_d.colour = WHITE;
        end else if (in_box) begin
            if (sel_q == SongNone && blink_phase_q) begin
                stage_d.colour = RED;
            end else begin
                stage_d.glyph  = 1'b1;
                stage_d.colour = song_bg(sel_q);
            end
        end else begin
            stage_d.colour = CYAN;
        end
    end

    // Stage 2: glyph bit select, ROM row arrives aligned with stage_q.
    always_comb begin
        pix_data_d = (stage_q.glyph && rom_row[stage_q.bit_idx]) ? BLACK : stage_q.colour;
    end

    vga_glyph_rom u_glyph_rom (
        .clk_i  (vga_clk),
        .rst_ni (sys_rst_n),
        .addr_i (rom_addr),
        .row_o  (rom_row)
    );

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q         <= SongNone;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            stage_q       <= '0;
            pix_data_q    <= BLACK;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            sel_q         <= sel_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            stage_q       <= stage_d;
            pix_data_q    <= pix_data_d;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign pix_data = pix_data_q;

endmodule

// File: tb/tb_vga_keyboard_pic.sv
// Directed bench for vga_keyboard_pic: key sweep, hold timer, song latch, blink and reset.
module tb_vga_keyboard_pic;

    localparam logic [11:0] C_BLACK = 12'h000;
    localparam logic [11:0] C_WHITE = 12'hFFF;
    localparam logic [11:0] C_GRAY  = 12'h888;
    localparam logic [11:0] C_RED   = 12'hF00;
    localparam logic [11:0] C_GREEN = 12'h0F0;
    localparam logic [11:0] C_CYAN  = 12'h0FF;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [6:0]  status;
    logic [3:0]  num;
    logic [11:0] pix_data;
    logic [11:0] exp_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    vga_keyboard_pic dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .status    (status),
        .num       (num),
        .pix_data  (pix_data)
    );

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one pixel, wait the two pipeline edges, compare.
    task automatic check_pix(input string tag, input int x, input int y, input logic [11:0] exp);
        @(negedge vga_clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check_eq(tag, pix_data, exp);
    endtask

    task automatic frame_start();
        @(negedge vga_clk);
        pix_x = 10'd0;
        pix_y = 10'd0;
        @(negedge vga_clk);
        pix_x = 10'd700;
        pix_y = 10'd100;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        status    = '0;
        num       = 4'd0;
        pix_x     = 10'd700;
        pix_y     = 10'd100;
        repeat (2) @(posedge vga_clk);
        #1;
        check_eq("reset_out", pix_data, C_BLACK);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Streamed line at y=100, one new pixel per clock, output checked two cycles later.
        pix_y = 10'd100;
        for (int i = 0; i < 450; i++) begin
            @(negedge vga_clk);
            if (i >= 2) begin
                exp_c = ((i - 2) < 280 && ((i - 2) % 40) == 39) ? C_BLACK : C_WHITE;
                check_eq($sformatf("line100 x=%0d", i - 2), pix_data, exp_c);
            end
            if (i < 448) pix_x = 10'(i);
        end

        // Key 2 pressed.
        @(negedge vga_clk);
        status = 7'b0000100;
        for (int i = 80; i < 122; i++) begin
            @(negedge vga_clk);
            if (i >= 82) begin
                exp_c = ((i - 2) == 119) ? C_BLACK : C_GRAY;
                check_eq($sformatf("key2 x=%0d", i - 2), pix_data, exp_c);
            end
            if (i < 120) pix_x = 10'(i);
        end
        check_pix("key1_unlit", 60, 100, C_WHITE);

        // Release: lit for 8 more frame starts.
        @(negedge vga_clk);
        status = 7'b0000000;
        check_pix("hold_f0", 85, 100, C_GRAY);
        for (int f = 1; f <= 8; f++) begin
            frame_start();
            check_pix($sformatf("hold_f%0d", f), 85, 100, (f < 8) ? C_GRAY : C_WHITE);
        end

        // Song 2 selected mid-frame: ignored until next frame start.
        check_pix("pre_num2", 300, 200, C_WHITE);
        num = 4'd2;
        check_pix("midframe_bg", 464, 2, C_RED);
        check_pix("midframe_fg", 448, 2, C_BLACK);
        frame_start();
        check_pix("song2_bg", 464, 2, C_GREEN);
        check_pix("song2_fg", 448, 2, C_BLACK);
        check_pix("song2_corner", 575, 31, C_GREEN);
        check_pix("song2_right", 576, 1, C_CYAN);
        check_pix("song2_below", 450, 32, C_CYAN);

        // Song 1: three-character box.
        num = 4'd1;
        frame_start();
        check_pix("song1_fg", 448, 2, C_BLACK);
        check_pix("song1_bg", 464, 2, C_CYAN);
        check_pix("song1_last", 543, 4, C_BLACK);
        check_pix("song1_outside", 544, 4, C_CYAN);
        check_pix("gap_edge", 447, 4, C_WHITE);
        check_pix("x_invalid", 700, 4, C_BLACK);
        check_pix("y_invalid", 100, 480, C_BLACK);

        // Asynchronous reset mid-line.
        check_pix("pre_reset", 100, 100, C_WHITE);
        @(posedge vga_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("async_reset", pix_data, C_BLACK);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        check_pix("post_reset_key", 100, 100, C_WHITE);
        check_pix("post_reset_sel", 464, 2, C_RED);
        frame_start();
        check_pix("post_reset_song1", 464, 2, C_CYAN);

        // No-choice blink over 120 frames.
        do_reset();
        for (int f = 0; f < 120; f++) begin
            exp_c = (((f / 30) % 2) == 0) ? C_BLACK : C_RED;
            check_pix($sformatf("blink_f%0d", f), 448, 2, exp_c);
            frame_start();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
